// File: rtl/fpu_pkg.sv
// Shared FP32 field constants, fflags bit positions and saturation values
// for the FP-to-integer conversion path.
package fpu_pkg;

    localparam int unsigned FP32_EXP_W  = 8;
    localparam int unsigned FP32_FRAC_W = 23;
    localparam int unsigned FP32_BIAS   = 127;

    // Biased-exponent landmarks: 2^0, 2^23 (no fraction left), 2^31, 2^32, inf/NaN
    localparam logic [FP32_EXP_W-1:0] EXP_BIAS    = 8'd127;
    localparam logic [FP32_EXP_W-1:0] EXP_NO_FRAC = 8'd150;
    localparam logic [FP32_EXP_W-1:0] EXP_2P31    = 8'd158;
    localparam logic [FP32_EXP_W-1:0] EXP_2P32    = 8'd159;
    localparam logic [FP32_EXP_W-1:0] EXP_INF     = 8'hFF;

    localparam int unsigned FFLAG_W  = 5;
    localparam int unsigned FFLAG_NV = 4;
    localparam int unsigned FFLAG_DZ = 3;
    localparam int unsigned FFLAG_OF = 2;
    localparam int unsigned FFLAG_UF = 1;
    localparam int unsigned FFLAG_NX = 0;

    localparam logic [31:0] SAT_S_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_S_MIN = 32'h8000_0000;
    localparam logic [31:0] SAT_U_MAX = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        OVR_NONE,
        OVR_S_MAX,
        OVR_S_MIN,
        OVR_U_MAX,
        OVR_ZERO_NV,
        OVR_ZERO
    } fcvt_ovr_e;

    function automatic logic ovr_sets_nv(input fcvt_ovr_e k);
        return k inside {OVR_S_MAX, OVR_S_MIN, OVR_U_MAX, OVR_ZERO_NV};
    endfunction

endpackage

// File: rtl/fcvt_issue_ctrl_if.sv
// Request/response bundle between the two FCVT requesters, the issue
// controller and FPU writeback.
interface fcvt_issue_ctrl_if #(
    parameter int unsigned TAG_W = 4
);
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [63:0]        req_a;
    logic [1:0]         req_unsigned;
    logic [2*TAG_W-1:0] req_tag;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [31:0]        rsp_result;
    logic [4:0]         rsp_flags;
    logic               rsp_id;
    logic [TAG_W-1:0]   rsp_tag;

    modport master (
        output req_valid, req_a, req_unsigned, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_id, rsp_tag
    );

    modport slave (
        input  req_valid, req_a, req_unsigned, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_id, rsp_tag
    );
endinterface

// File: rtl/fcvt_f2i_conv.sv
// Combinational FP32 to 32-bit integer converter, truncating toward zero.
// Output is only meaningful for |x| < 2^32; the caller applies saturation.
module fcvt_f2i_conv
    import fpu_pkg::*;
(
    input  logic [31:0] a,
    output logic [31:0] result
);
    logic [FP32_EXP_W-1:0] biased_exp;
    logic [23:0]           mant;
    logic [4:0]            e_unb;
    logic [31:0]           mag;

    always_comb begin
        biased_exp = a[30:23];
        mant       = {|biased_exp, a[22:0]};
        e_unb      = 5'(biased_exp - EXP_BIAS);
        mag        = '0;
        // Left-align the significand, then shift right by 31-E to drop the fraction
        if (biased_exp >= EXP_BIAS && biased_exp <= EXP_2P31) begin
            mag = {mant, 8'b0} >> (5'd31 - e_unb);
        end
        result = a[31] ? -mag : mag;
    end
endmodule

// File: rtl/fcvt_rr_arb.sv
// Two-way round-robin arbiter; the last-grant pointer moves only on an
// accepted transfer and resets to 1 so requester 0 wins first.
module fcvt_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       grant,
    output logic       grant_valid
);
    logic last_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant;
        end
    end

    always_comb begin
        grant_valid = |req;
        if (&req) begin
            grant = ~last_grant;
        end else begin
            grant = req[1];
        end
    end
endmodule

// File: rtl/fcvt_issue_ctrl.sv
// FCVT.W.S / FCVT.WU.S issue controller: RR arbitration, S1/S2 pipeline,
// saturation and fflags. Flag logic compiled in with FCVT_ISSUE_CTRL_FLAGS_EN.
module fcvt_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    fcvt_issue_ctrl_if.slave bus
);
    logic                  grant;
    logic                  grant_valid;
    logic                  xfer;
    logic                  advance;
    logic                  s1_accept;

    logic                  s1_valid;
    logic [31:0]           s1_a;
    logic                  s1_unsigned;
    logic                  s1_id;
    logic [TAG_W-1:0]      s1_tag;

    logic                  s1_sign;
    logic [FP32_EXP_W-1:0] s1_exp;
    logic [22:0]           s1_frac;
    logic                  s1_nan;
    fcvt_ovr_e             ovr;
    logic [31:0]           conv_result;
    logic [31:0]           s1_result;
    logic [FFLAG_W-1:0]    s1_flags;

    logic                  s2_valid;
    logic [31:0]           s2_result;
    logic [FFLAG_W-1:0]    s2_flags;
    logic                  s2_id;
    logic [TAG_W-1:0]      s2_tag;

    assign advance   = ~s2_valid | bus.rsp_ready;
    assign s1_accept = ~s1_valid | advance;

    fcvt_rr_arb u_arb (
        .clk        (clk),
        .rst        (rst),
        .req        (bus.req_valid),
        .accept     (xfer),
        .grant      (grant),
        .grant_valid(grant_valid)
    );

    always_comb begin
        bus.req_ready = '0;
        if (!rst && grant_valid && s1_accept) begin
            bus.req_ready[grant] = 1'b1;
        end
    end

    assign xfer = |(bus.req_valid & bus.req_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_a        <= '0;
            s1_unsigned <= 1'b0;
            s1_id       <= 1'b0;
            s1_tag      <= '0;
        end else if (s1_accept) begin
            s1_valid <= xfer;
            if (xfer) begin
                s1_a        <= grant ? bus.req_a[63:32] : bus.req_a[31:0];
                s1_unsigned <= bus.req_unsigned[grant];
                s1_id       <= grant;
                s1_tag      <= grant ? bus.req_tag[2*TAG_W-1:TAG_W] : bus.req_tag[TAG_W-1:0];
            end
        end
    end

    fcvt_f2i_conv u_conv (
        .a     (s1_a),
        .result(conv_result)
    );

    assign s1_sign = s1_a[31];
    assign s1_exp  = s1_a[30:23];
    assign s1_frac = s1_a[22:0];
    assign s1_nan  = (s1_exp == EXP_INF) && (s1_frac != '0);

    // Infinities fall out of the exponent compares since EXP_INF exceeds every bound
    always_comb begin
        ovr = OVR_NONE;
        if (s1_nan) begin
            ovr = s1_unsigned ? OVR_U_MAX : OVR_S_MAX;
        end else if (!s1_unsigned) begin
            if (!s1_sign && s1_exp >= EXP_2P31) begin
                ovr = OVR_S_MAX;
            end else if (s1_sign && (s1_exp > EXP_2P31 ||
                                     (s1_exp == EXP_2P31 && s1_frac != '0))) begin
                ovr = OVR_S_MIN;
            end
        end else begin
            if (!s1_sign && s1_exp >= EXP_2P32) begin
                ovr = OVR_U_MAX;
            end else if (s1_sign && s1_exp >= EXP_BIAS) begin
                ovr = OVR_ZERO_NV;
            end else if (s1_sign) begin
                ovr = OVR_ZERO;
            end
        end
    end

    always_comb begin
        case (ovr)
            OVR_S_MAX:            s1_result = SAT_S_MAX;
            OVR_S_MIN:            s1_result = SAT_S_MIN;
            OVR_U_MAX:            s1_result = SAT_U_MAX;
            OVR_ZERO_NV, OVR_ZERO: s1_result = '0;
            default:              s1_result = conv_result;
        endcase
    end

`ifdef FCVT_ISSUE_CTRL_FLAGS_EN
    logic frac_lost;

    always_comb begin
        frac_lost = 1'b0;
        if (s1_exp < EXP_BIAS) begin
            frac_lost = |s1_a[30:0];
        end else if (s1_exp < EXP_NO_FRAC) begin
            frac_lost = |(s1_frac & (23'h7F_FFFF >> (s1_exp - EXP_BIAS)));
        end
        s1_flags           = '0;
        s1_flags[FFLAG_NV] = ovr_sets_nv(ovr);
        s1_flags[FFLAG_NX] = frac_lost & ~ovr_sets_nv(ovr);
    end
`else
    assign s1_flags = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_flags  <= '0;
            s2_id     <= 1'b0;
            s2_tag    <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_result <= s1_result;
                s2_flags  <= s1_flags;
                s2_id     <= s1_id;
                s2_tag    <= s1_tag;
            end
        end
    end

    assign bus.rsp_valid  = s2_valid;
    assign bus.rsp_result = s2_result;
    assign bus.rsp_flags  = s2_flags;
    assign bus.rsp_id     = s2_id;
    assign bus.rsp_tag    = s2_tag;
endmodule
